// File: rtl/mem_slave_ram.sv
// mem_slave_ram: single-port word RAM that answers the core's memory request bus with programmable wait states.
// Optional feature macro MEM_RANGE_CHK_EN: out-of-range addresses raise mem_err_o, read zero and drop the write.
module mem_slave_ram #(
    parameter int    DEPTH     = 4096,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_raddr_i,
    input  logic [31:0] mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    output logic        hold_req_o
);
    localparam int AW = $clog2(DEPTH);

    // state | meaning
    // IDLE  | no request outstanding
    // WAIT  | request latched, counting wait states
    // RESP  | access committed, ack asserted for this cycle
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] raddr_q;
    logic [AW-1:0] waddr_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic          bad_q;
    logic [31:0]   ram [DEPTH];

    logic          bad_in;
    logic          go_resp;
    logic [AW-1:0] c_raddr;
    logic [AW-1:0] c_waddr;
    logic          c_we;
    logic [31:0]   c_wdata;
    logic          c_bad;
    logic          unused_addr;

    // Low address bits are dropped and upper bits alias unless the range check consumes them.
    assign unused_addr = ^{mem_raddr_i, mem_waddr_i};

`ifdef MEM_RANGE_CHK_EN
    logic r_oor;
    logic w_oor;
    assign r_oor  = (mem_raddr_i >> (AW + 2)) != 32'd0;
    assign w_oor  = (mem_waddr_i >> (AW + 2)) != 32'd0;
    assign bad_in = r_oor | (mem_we_i & w_oor);
`else
    assign bad_in = 1'b0;
`endif

    // With zero wait states the commit edge is also the capture edge, so it uses the live inputs.
    always_comb begin
        go_resp = 1'b0;
        c_raddr = raddr_q;
        c_waddr = waddr_q;
        c_we    = we_q;
        c_wdata = wdata_q;
        c_bad   = bad_q;
        if (state == WAIT) begin
            go_resp = (wait_cnt == 4'd0);
        end else if (mem_req_i && (LATENCY == 0)) begin
            go_resp = 1'b1;
            c_raddr = mem_raddr_i[2 +: AW];
            c_waddr = mem_waddr_i[2 +: AW];
            c_we    = mem_we_i;
            c_wdata = mem_wdata_i;
            c_bad   = bad_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            mem_ack_o   <= 1'b0;
            mem_err_o   <= 1'b0;
            mem_rdata_o <= 32'd0;
        end else begin
            mem_ack_o <= go_resp;
            mem_err_o <= go_resp & c_bad;
            if (go_resp) begin
                mem_rdata_o <= c_bad ? 32'd0 : ram[c_raddr];
            end
            case (state)
                IDLE, RESP: begin
                    if (mem_req_i) begin
                        raddr_q <= mem_raddr_i[2 +: AW];
                        waddr_q <= mem_waddr_i[2 +: AW];
                        we_q    <= mem_we_i;
                        wdata_q <= mem_wdata_i;
                        bad_q   <= bad_in;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 4'(LATENCY - 1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= RESP;
                    else wait_cnt <= wait_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset abandons a pending access, so the write port is gated by rst as well.
    always_ff @(posedge clk) begin
        if (rst && go_resp && c_we && !c_bad) begin
            ram[c_waddr] <= c_wdata;
        end
    end

    assign hold_req_o = mem_req_i & ~mem_ack_o;

endmodule
